// File: rtl/ahb_sram_bank_ctrl.sv
// AHB-Lite slave fronting N_BANK single-port synchronous SRAM banks.
// One-entry posted write buffer with byte-merged read-after-write forwarding.
module ahb_sram_bank_ctrl #(
    parameter int N_BANK         = 2,
    parameter int BANK_DEPTH     = 1024,
    parameter int RD_WAIT        = 0,
    parameter bit INVERT_CE_EN   = 1'b0,
    parameter bit INVERT_BYTE_EN = 1'b0,
    localparam int AW = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic                  HREADY,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HADDR,
    input  logic [31:0]           HWDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [N_BANK-1:0]     sram_ce,
    output logic                  sram_we,
    output logic [3:0]            sram_be,
    output logic [AW-1:0]         sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [32*N_BANK-1:0]  sram_rdata
);

    localparam int BW = (N_BANK > 1) ? $clog2(N_BANK) : 1;
    localparam logic [32:0] LIMIT = 33'(N_BANK) * 33'(BANK_DEPTH) * 33'd4;
    localparam logic [3:0] LAST = 4'(RD_WAIT + 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        RD_END,
        ERR1,
        ERR2
    } state_t;

    state_t state;
    state_t state_n;
    logic [3:0] cnt;

    logic [31:0] bank_full;
    logic [BW-1:0] a_bank;
    logic [AW-1:0] a_word;
    logic [3:0] a_be;
    logic a_oor;
    logic a_mis;
    logic acc;
    logic acc_err;
    logic acc_rd;
    logic acc_wr;
    logic ready;
    logic issue;
    logic rd_done;
    logic drain;
    logic unused_bits;

    logic [BW-1:0] rd_bank;
    logic [AW-1:0] rd_word;

    logic wdp;
    logic [BW-1:0] wdp_bank;
    logic [AW-1:0] wdp_word;
    logic [3:0] wdp_be;

    logic bv;
    logic [BW-1:0] bb;
    logic [AW-1:0] bw;
    logic [3:0] bbe;
    logic [31:0] bd;

    logic sh_hit;
    logic [3:0] sh_be;
    logic [31:0] sh_data;

    logic [31:0] bank_rdata;
    logic [31:0] merged;
    logic [31:0] rdata_q;
    logic [AW-1:0] last_addr;
    logic [31:0] last_wdata;
    logic [N_BANK-1:0] ce_raw;
    logic [3:0] be_raw;

    // Address-phase decode
    assign bank_full = HADDR >> (AW + 2);
    assign a_bank = bank_full[BW-1:0];
    assign a_word = HADDR[AW+1:2];
    assign a_oor = {1'b0, HADDR} >= LIMIT;
    assign a_mis = (HSIZE > 3'd2)
                || (HSIZE == 3'd1 && HADDR[0])
                || (HSIZE == 3'd2 && HADDR[1:0] != 2'b00);
    assign unused_bits = ^{HTRANS[0], bank_full};

    always_comb begin
        a_be = 4'b1111;
        case (HSIZE)
            3'd0:    a_be = 4'b0001 << HADDR[1:0];
            3'd1:    a_be = HADDR[1] ? 4'b1100 : 4'b0011;
            default: a_be = 4'b1111;
        endcase
    end

    assign acc = HSEL & HREADY & HTRANS[1] & ready;
    assign acc_err = acc & (a_oor | a_mis);
    assign acc_rd = acc & ~(a_oor | a_mis) & ~HWRITE;
    assign acc_wr = acc & ~(a_oor | a_mis) & HWRITE;

    // State register
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state <= IDLE;
            cnt <= 4'd0;
        end else begin
            state <= state_n;
            if (state == READ && state_n == READ) begin
                cnt <= cnt + 4'd1;
            end else begin
                cnt <= 4'd0;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE, RD_END, ERR2: begin
                if (acc_err) begin
                    state_n = ERR1;
                end else if (acc_rd) begin
                    state_n = READ;
                end else begin
                    state_n = IDLE;
                end
            end
            READ: begin
                if (cnt == LAST) begin
                    state_n = RD_END;
                end
            end
            ERR1:    state_n = ERR2;
            default: state_n = IDLE;
        endcase
    end

    // Bus-side outputs
    always_comb begin
        ready = 1'b1;
        HRESP = 1'b0;
        issue = 1'b0;
        rd_done = 1'b0;
        unique case (state)
            READ: begin
                ready = 1'b0;
                issue = (cnt == 4'd0);
                rd_done = (cnt == LAST);
            end
            ERR1: begin
                ready = 1'b0;
                HRESP = 1'b1;
            end
            ERR2:    HRESP = 1'b1;
            default: ready = 1'b1;
        endcase
    end

    assign HREADYOUT = ready;
    assign HRDATA = rdata_q;

    // A read issue owns the SRAM port; the buffer drains any other cycle
    assign drain = bv & ~issue;

    always_comb begin
        ce_raw = '0;
        be_raw = 4'b0000;
        sram_we = 1'b0;
        sram_addr = last_addr;
        sram_wdata = last_wdata;
        if (issue) begin
            ce_raw[rd_bank] = 1'b1;
            be_raw = 4'b1111;
            sram_addr = rd_word;
        end else if (bv) begin
            ce_raw[bb] = 1'b1;
            be_raw = bbe;
            sram_we = 1'b1;
            sram_addr = bw;
            sram_wdata = bd;
        end
    end

    assign sram_ce = INVERT_CE_EN ? ~ce_raw : ce_raw;
    assign sram_be = INVERT_BYTE_EN ? ~be_raw : be_raw;

    assign bank_rdata = sram_rdata[int'(rd_bank) * 32 +: 32];

    always_comb begin
        merged = bank_rdata;
        for (int i = 0; i < 4; i++) begin
            if (sh_hit && sh_be[i]) begin
                merged[8*i +: 8] = sh_data[8*i +: 8];
            end
        end
    end

    // Datapath, write buffer and forwarding snapshot
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            rd_bank <= '0;
            rd_word <= '0;
            wdp <= 1'b0;
            wdp_bank <= '0;
            wdp_word <= '0;
            wdp_be <= 4'b0000;
            bv <= 1'b0;
            bb <= '0;
            bw <= '0;
            bbe <= 4'b0000;
            bd <= 32'd0;
            sh_hit <= 1'b0;
            sh_be <= 4'b0000;
            sh_data <= 32'd0;
            rdata_q <= 32'd0;
            last_addr <= '0;
            last_wdata <= 32'd0;
        end else begin
            if (acc_rd) begin
                rd_bank <= a_bank;
                rd_word <= a_word;
            end
            wdp <= acc_wr;
            if (acc_wr) begin
                wdp_bank <= a_bank;
                wdp_word <= a_word;
                wdp_be <= a_be;
            end
            if (drain) begin
                bv <= 1'b0;
            end
            if (wdp) begin
                bv <= 1'b1;
                bb <= wdp_bank;
                bw <= wdp_word;
                bbe <= wdp_be;
                bd <= HWDATA;
            end
            if (issue) begin
                sh_hit <= bv && (bb == rd_bank) && (bw == rd_word);
                sh_be <= bbe;
                sh_data <= bd;
            end
            if (rd_done) begin
                rdata_q <= merged;
            end
            last_addr <= sram_addr;
            last_wdata <= sram_wdata;
        end
    end

endmodule

// File: tb/tb_ahb_sram_bank_ctrl.sv
// Directed bench for ahb_sram_bank_ctrl: instance a (RD_WAIT=0) and
// instance b (RD_WAIT=3, inverted chip/byte enables), each with an SRAM model.
module tb_ahb_sram_bank_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic pre;
    logic sel_a;
    logic sel_b;
    logic [1:0] htrans;
    logic [2:0] hsize;
    logic hwrite;
    logic [31:0] haddr;
    logic [31:0] hwdata;

    logic ro_a, resp_a, we_a;
    logic [31:0] rdat_a, wd_a;
    logic [1:0] ce_a;
    logic [3:0] be_a;
    logic [9:0] ad_a;
    logic [63:0] sr_a;

    logic ro_b, resp_b, we_b;
    logic [31:0] rdat_b, wd_b;
    logic [1:0] ce_b;
    logic [3:0] be_b;
    logic [9:0] ad_b;
    logic [63:0] sr_b;

    int total = 0;
    int bad = 0;

    ahb_sram_bank_ctrl #(
        .N_BANK(2), .BANK_DEPTH(1024), .RD_WAIT(0),
        .INVERT_CE_EN(1'b0), .INVERT_BYTE_EN(1'b0)
    ) dut_a (
        .HCLK(clk), .HRESET(rst), .HSEL(sel_a), .HREADY(ro_a),
        .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite),
        .HADDR(haddr), .HWDATA(hwdata),
        .HREADYOUT(ro_a), .HRESP(resp_a), .HRDATA(rdat_a),
        .sram_ce(ce_a), .sram_we(we_a), .sram_be(be_a),
        .sram_addr(ad_a), .sram_wdata(wd_a), .sram_rdata(sr_a)
    );

    ahb_sram_bank_ctrl #(
        .N_BANK(2), .BANK_DEPTH(1024), .RD_WAIT(3),
        .INVERT_CE_EN(1'b1), .INVERT_BYTE_EN(1'b1)
    ) dut_b (
        .HCLK(clk), .HRESET(rst), .HSEL(sel_b), .HREADY(ro_b),
        .HTRANS(htrans), .HSIZE(hsize), .HWRITE(hwrite),
        .HADDR(haddr), .HWDATA(hwdata),
        .HREADYOUT(ro_b), .HRESP(resp_b), .HRDATA(rdat_b),
        .sram_ce(ce_b), .sram_we(we_b), .sram_be(be_b),
        .sram_addr(ad_b), .sram_wdata(wd_b), .sram_rdata(sr_b)
    );

    function automatic logic [31:0] pat(input int b, input int w);
        if (b == 0 && w == 1) return 32'h11223344;
        return 32'hC0DE0000 | 32'(b << 12) | 32'(w);
    endfunction

    // SRAM model a: one cycle read latency
    logic [31:0] mem_a [2][1024];
    logic [31:0] q_a [2];
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (pre) begin
                q_a[b] <= 32'd0;
                for (int w = 0; w < 1024; w++) mem_a[b][w] <= pat(b, w);
            end else if (ce_a[b]) begin
                if (we_a) begin
                    for (int i = 0; i < 4; i++)
                        if (be_a[i]) mem_a[b][ad_a][8*i +: 8] <= wd_a[8*i +: 8];
                end else begin
                    q_a[b] <= mem_a[b][ad_a];
                end
            end
        end
    end
    assign sr_a = {q_a[1], q_a[0]};

    // SRAM model b: four cycle read latency, active-low enables
    logic [31:0] mem_b [2][1024];
    logic [31:0] p_b [2][4];
    always @(posedge clk) begin
        for (int b = 0; b < 2; b++) begin
            if (pre) begin
                for (int s = 0; s < 4; s++) p_b[b][s] <= 32'd0;
                for (int w = 0; w < 1024; w++) mem_b[b][w] <= pat(b, w);
            end else begin
                for (int s = 1; s < 4; s++) p_b[b][s] <= p_b[b][s-1];
                if (!ce_b[b]) begin
                    if (we_b) begin
                        for (int i = 0; i < 4; i++)
                            if (!be_b[i]) mem_b[b][ad_b][8*i +: 8] <= wd_b[8*i +: 8];
                    end else begin
                        p_b[b][0] <= mem_b[b][ad_b];
                    end
                end
            end
        end
    end
    assign sr_b = {p_b[1][3], p_b[0][3]};

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ap(input bit b, input bit w, input logic [2:0] sz, input logic [31:0] a);
        sel_a = !b;
        sel_b = b;
        htrans = 2'b10;
        hwrite = w;
        hsize = sz;
        haddr = a;
    endtask

    task automatic idle_bus();
        sel_a = 1'b0;
        sel_b = 1'b0;
        htrans = 2'b00;
        hwrite = 1'b0;
    endtask

    function automatic logic rdy(input bit b);
        return b ? ro_b : ro_a;
    endfunction

    task automatic rd(input bit b, input logic [31:0] a, output logic [31:0] d,
                      output int waits, output logic [31:0] ce_i, output logic [31:0] ad_i);
        nxt();
        ap(b, 1'b0, 3'd2, a);
        nxt();
        idle_bus();
        waits = 0;
        @(negedge clk);
        ce_i = b ? 32'(ce_b) : 32'(ce_a);
        ad_i = b ? 32'(ad_b) : 32'(ad_a);
        while (rdy(b) !== 1'b1 && waits < 20) begin
            waits++;
            nxt();
            @(negedge clk);
        end
        d = b ? rdat_b : rdat_a;
    endtask

    task automatic wr(input bit b, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
        nxt();
        ap(b, 1'b1, sz, a);
        nxt();
        idle_bus();
        hwdata = d;
        @(negedge clk);
        chk("wr_ready", 32'(rdy(b)), 32'd1);
    endtask

    task automatic err(input bit w, input logic [2:0] sz, input logic [31:0] a);
        nxt();
        ap(1'b0, w, sz, a);
        nxt();
        idle_bus();
        hwdata = 32'h77777777;
        @(negedge clk);
        chk("err1_ready", 32'(ro_a), 32'd0);
        chk("err1_resp", 32'(resp_a), 32'd1);
        chk("err1_ce", 32'(ce_a), 32'd0);
        nxt();
        @(negedge clk);
        chk("err2_ready", 32'(ro_a), 32'd1);
        chk("err2_resp", 32'(resp_a), 32'd1);
        chk("err2_ce", 32'(ce_a), 32'd0);
        chk("err2_we", 32'(we_a), 32'd0);
    endtask

    logic [31:0] d, ce_i, ad_i;
    int waits;
    logic [31:0] sd [4];

    initial begin
        sd[0] = 32'hA5A50001;
        sd[1] = 32'h11223344;
        sd[2] = 32'h0BADF00D;
        sd[3] = 32'hCAFE1234;
        rst = 1'b1;
        pre = 1'b1;
        idle_bus();
        hsize = 3'd0;
        haddr = 32'd0;
        hwdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        pre = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(ro_a), 32'd1);
        chk("rst_resp", 32'(resp_a), 32'd0);
        chk("rst_rdata", rdat_a, 32'd0);
        chk("rst_ce", 32'(ce_a), 32'd0);
        chk("rst_we", 32'(we_a), 32'd0);
        chk("rst_be", 32'(be_a), 32'd0);
        chk("rst_addr", 32'(ad_a), 32'd0);
        chk("rst_wdata", wd_a, 32'd0);
        chk("rst_ce_inv", 32'(ce_b), 32'h3);
        chk("rst_be_inv", 32'(be_b), 32'hF);

        // byte write then back-to-back read of the same word: merged forward
        nxt();
        ap(1'b0, 1'b1, 3'd0, 32'h5);
        nxt();
        hwdata = 32'h0000AB00;
        ap(1'b0, 1'b0, 3'd2, 32'h4);
        nxt();
        idle_bus();
        @(negedge clk);
        chk("bfwd_issue_we", 32'(we_a), 32'd0);
        nxt();
        @(negedge clk);
        chk("bfwd_drain_we", 32'(we_a), 32'd1);
        chk("bfwd_drain_be", 32'(be_a), 32'h2);
        chk("bfwd_drain_wd", wd_a, 32'h0000AB00);
        nxt();
        @(negedge clk);
        chk("bfwd_ready", 32'(ro_a), 32'd1);
        chk("bfwd_rdata", rdat_a, 32'h1122AB44);
        rd(1'b0, 32'h4, d, waits, ce_i, ad_i);
        chk("byte_sram_rdata", d, 32'h1122AB44);
        chk("byte_sram_waits", 32'(waits), 32'd2);

        // word write then back-to-back read: forwarded, drain after issue
        nxt();
        ap(1'b0, 1'b1, 3'd2, 32'h4);
        nxt();
        hwdata = 32'hDEADBEEF;
        ap(1'b0, 1'b0, 3'd2, 32'h4);
        @(negedge clk);
        chk("fwd_wr_ready", 32'(ro_a), 32'd1);
        nxt();
        idle_bus();
        @(negedge clk);
        chk("fwd_issue_ready", 32'(ro_a), 32'd0);
        chk("fwd_issue_ce", 32'(ce_a), 32'h1);
        chk("fwd_issue_we", 32'(we_a), 32'd0);
        chk("fwd_issue_be", 32'(be_a), 32'hF);
        chk("fwd_issue_addr", 32'(ad_a), 32'd1);
        nxt();
        @(negedge clk);
        chk("fwd_drain_ready", 32'(ro_a), 32'd0);
        chk("fwd_drain_we", 32'(we_a), 32'd1);
        chk("fwd_drain_addr", 32'(ad_a), 32'd1);
        chk("fwd_drain_wd", wd_a, 32'hDEADBEEF);
        nxt();
        @(negedge clk);
        chk("fwd_ready", 32'(ro_a), 32'd1);
        chk("fwd_resp", 32'(resp_a), 32'd0);
        chk("fwd_rdata", rdat_a, 32'hDEADBEEF);

        // bank decode
        rd(1'b0, 32'h1000, d, waits, ce_i, ad_i);
        chk("bank1_ce", ce_i, 32'h2);
        chk("bank1_addr", ad_i, 32'd0);
        chk("bank1_rdata", d, 32'hC0DE1000);
        rd(1'b0, 32'hFFC, d, waits, ce_i, ad_i);
        chk("bank0_ce", ce_i, 32'h1);
        chk("bank0_addr", ad_i, 32'd1023);
        chk("bank0_rdata", d, 32'hC0DE03FF);
        chk("bank0_waits", 32'(waits), 32'd2);

        // error responses, then a normal read
        err(1'b0, 3'd2, 32'h2000);
        err(1'b1, 3'd1, 32'h3);
        rd(1'b0, 32'h8, d, waits, ce_i, ad_i);
        chk("post_err_rdata", d, 32'hC0DE0002);
        chk("post_err_waits", 32'(waits), 32'd2);

        // reset during a read issue drops the buffered write
        nxt();
        ap(1'b0, 1'b1, 3'd2, 32'h8);
        nxt();
        hwdata = 32'h55555555;
        ap(1'b0, 1'b0, 3'd2, 32'h100);
        nxt();
        idle_bus();
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", 32'(ro_a), 32'd1);
        chk("mid_rst_resp", 32'(resp_a), 32'd0);
        chk("mid_rst_rdata", rdat_a, 32'd0);
        chk("mid_rst_ce", 32'(ce_a), 32'd0);
        chk("mid_rst_we", 32'(we_a), 32'd0);
        rd(1'b0, 32'h8, d, waits, ce_i, ad_i);
        chk("dropped_wr_rdata", d, 32'hC0DE0002);

        // streaming writes on instance b
        for (int k = 0; k < 6; k++) begin
            nxt();
            if (k >= 1 && k <= 4) hwdata = sd[k-1];
            if (k <= 3) ap(1'b1, 1'b1, 3'd2, 32'(4 * k));
            else idle_bus();
            @(negedge clk);
            if (k <= 4) chk("st_ready", 32'(ro_b), 32'd1);
            if (k >= 2) begin
                chk("st_we", 32'(we_b), 32'd1);
                chk("st_ce", 32'(ce_b), 32'h2);
                chk("st_be", 32'(be_b), 32'h0);
                chk("st_addr", 32'(ad_b), 32'(k - 2));
                chk("st_wdata", wd_b, sd[k-2]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            rd(1'b1, 32'(4 * k), d, waits, ce_i, ad_i);
            chk("st_rd_data", d, sd[k]);
            chk("st_rd_waits", 32'(waits), 32'd5);
            chk("st_rd_ce", ce_i, 32'h2);
        end

        // byte write with inverted byte enables
        wr(1'b1, 3'd0, 32'h5, 32'h0000AB00);
        nxt();
        @(negedge clk);
        chk("inv_be_we", 32'(we_b), 32'd1);
        chk("inv_be", 32'(be_b), 32'hD);
        chk("inv_be_addr", 32'(ad_b), 32'd1);
        rd(1'b1, 32'h4, d, waits, ce_i, ad_i);
        chk("inv_be_rdata", d, 32'h1122AB44);

        nxt();
        @(negedge clk);
        chk("end_ce_a", 32'(ce_a), 32'd0);
        chk("end_ce_b", 32'(ce_b), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_sram_bank_ctrl.md
# ahb_sram_bank_ctrl

AHB-Lite slave that maps a flat byte address space onto `N_BANK` single-port synchronous SRAM banks. It is the parametrised successor to the two-bank SRAM controller, adding the following:
- configurable bank count, bank depth and read latency;
- a one-entry posted write buffer, so writes complete with zero wait states;
- read-after-write forwarding from that buffer;
- AHB ERROR responses for out-of-range and misaligned transfers.

It sits between the AHB-Lite interconnect and the SRAM macros.

## Interface
Parameters:
- `N_BANK`, 2: number of SRAM banks (1..8).
- `BANK_DEPTH`, 1024: 32-bit words per bank. Must be a power of two. `AW = clog2(BANK_DEPTH)`.
- `RD_WAIT`, 0: extra SRAM read latency cycles beyond one (0..7).
- `INVERT_CE_EN`, 0: 1 makes `sram_ce` active-low.
- `INVERT_BYTE_EN`, 0: 1 makes `sram_be` active-low.

Ports:
- `HCLK` in 1: single clock.
- `HRESET` in 1: synchronous, active-high reset.
- `HSEL` in 1: slave select.
- `HREADY` in 1: bus ready (address phase qualifier).
- `HTRANS` in 2: transfer type.
- `HSIZE` in 3: transfer size.
- `HWRITE` in 1: 1 = write.
- `HADDR` in 32: byte address.
- `HWDATA` in 32: write data.
- `HREADYOUT` out 1: slave ready.
- `HRESP` out 1: 1 = ERROR.
- `HRDATA` out 32: read data.
- `sram_ce` out N_BANK: per-bank chip enable.
- `sram_we` out 1: write enable, active-high.
- `sram_be` out 4: byte enables.
- `sram_addr` out AW: word index within the bank.
- `sram_wdata` out 32: write data.
- `sram_rdata` in 32*N_BANK: bank `b` occupies bits [32b+31:32b]. Valid `RD_WAIT+1` cycles after a read enable.

## Operation

**Address phase accept:** `HSEL & HREADY & HTRANS[1]`. IDLE/BUSY transfers get a zero-wait OKAY.

**Decode:**
- Word index = `HADDR[AW+1:2]`.
- Bank = `HADDR[31:AW+2]`.
- Out-of-range when `HADDR >= N_BANK*BANK_DEPTH*4`.
- Misaligned when `HSIZE>2`, or `HSIZE==1 & HADDR[0]`, or `HSIZE==2 & HADDR[1:0]!=0`.

**Byte lanes (little-endian):**
- HSIZE 0: lane `HADDR[1:0]`.
- HSIZE 1: lanes `{HADDR[1],1}`/`{HADDR[1],0}`.
- HSIZE 2: all lanes.

**FSM states:**
- `IDLE`: HREADYOUT=1.
- `READ`: HREADYOUT=0; counter runs 0..RD_WAIT+1.
- `RD_END`: HREADYOUT=1; HRDATA valid.
- `ERR1`: HREADYOUT=0, HRESP=1.
- `ERR2`: HREADYOUT=1, HRESP=1.

**FSM transitions:**
- Accepted error transfer: → `ERR1` → `ERR2` → `IDLE`, or directly into a newly accepted transfer. No SRAM access.
- Accepted read: → `READ`. The first READ cycle is the issue cycle: `sram_ce[bank]` active, `sram_we=0`, all `sram_be` active.
- At counter `RD_WAIT+1`: sample `sram_rdata[bank]` into HRDATA → `RD_END`.
- `RD_END`/`IDLE` may accept a new transfer in the same cycle.
- Accepted write: stays `IDLE`. The data phase is zero-wait. At the end of the data phase, `{bank, word, be, HWDATA}` loads the write buffer.

**Write buffer (one entry):**
- Drains in any cycle that is not a read issue cycle: `sram_ce[bank]`, `sram_we=1`, `sram_be=be`, `sram_wdata=data`.
- Drain and load of a new entry in the same cycle is permitted. Back-to-back writes therefore never stall.

**Forwarding:**
- On the read issue cycle, the buffer is snapshotted: `hit = valid & same bank & same word`, plus the buffer's `be` and `data`.
- Each HRDATA byte `i` = `hit & be[i]` ? snapshot byte : `sram_rdata` byte.
- HRDATA always returns the full word. HRDATA holds its value until the next read completes.

**SRAM outputs when idle:** `sram_ce` inactive, `sram_we=0`, `sram_be` inactive. `sram_addr`/`sram_wdata` hold their last values.

**Reset (HRESET=1 at a clock edge):**
- State → `IDLE`; HREADYOUT=1, HRESP=0, HRDATA=0.
- `sram_ce` all inactive (0, or all-1 when `INVERT_CE_EN`); `sram_we=0`; `sram_be` inactive.
- `sram_addr=0`, `sram_wdata=0`.
- Write buffer invalidated: a pending write is discarded. An in-flight read or error is aborted.

## Timing
- Write: data phase of 1 cycle, 0 wait states. SRAM commit happens at the earliest in the cycle after the data phase. It is deferred only by a read issue cycle, which happens at most once consecutively.
- Read: data phase of `RD_WAIT+3` cycles (`RD_WAIT+2` wait states). Issue happens at data phase cycle 1; HRDATA is valid with HREADYOUT=1 in the final cycle.
- Write followed immediately by a read: the read issue blocks the drain, and the drain happens in the next READ wait cycle. Forwarding guarantees the read returns the new data.
- ERROR response: two cycles, per the AHB-Lite rule.

## Test plan
- **Reset:** assert HRESET during a read wait. Next cycle: HREADYOUT=1, HRESP=0, HRDATA=0, sram_ce=0, sram_we=0. A later read of the word written before reset returns the old SRAM contents (buffered write dropped).
- **Forwarding:** word write `0xDEADBEEF` to 0x4, then a back-to-back word read of 0x4 with RD_WAIT=0. Read returns `0xDEADBEEF` after 2 wait states. The SRAM write (sram_we=1, sram_addr=1) occurs in the cycle after the read issue.
- **Byte write:** byte write `0x0000AB00` to 0x5 → sram_be=4'b0010 on commit. A read of 0x4 with SRAM content `0x11223344` returns `0x1122AB44`. Repeat with INVERT_BYTE_EN=1 → sram_be=4'b1101.
- **Bank decode (N_BANK=2, BANK_DEPTH=1024):** read 0x1000 → sram_ce=2'b10, sram_addr=0, HRDATA from bank 1. Read 0xFFC → sram_ce=2'b01, sram_addr=1023.
- **Errors:** word read to 0x2000, and halfword write to 0x3. Each gives HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1. sram_ce stays inactive. The next OKAY transfer proceeds normally.
- **Streaming writes:** four back-to-back word writes to 0x0–0xC with HREADYOUT constantly 1. Four SRAM commits occur in consecutive cycles. Readback returns all four values with RD_WAIT=3 (5 wait states each).
